// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Mips16 program counter and next-fetch-address selection with
//               branch/jump redirect, fixed-length flush, stall and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_WIDTH     = 10,
    parameter int IMM_WIDTH    = 7,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_req,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_pc,
    input  logic [IMM_WIDTH-1:0] immediate,
    input  logic                 jump_req,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 halt,
    input  logic                 resume,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 pc_valid,
    output logic                 flush,
    output logic                 redirect,
    output logic                 halted
);

    localparam int CNT_W = 3;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_flush = 2'd1;
    localparam logic [1:0] c_st_halt  = 2'd2;

    localparam logic [CNT_W-1:0]    c_flush_init = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] c_reset_pc   = PC_WIDTH'(RESET_PC);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_valid;
    logic                r_flush;
    logic                r_redirect;
    logic                r_halted;

    logic                w_branch;
    logic                w_redirect;
    logic [PC_WIDTH-1:0] w_imm_ext;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_inc;

    // Branch is the older instruction, so it beats a simultaneous jump.
    assign w_branch   = branch_req & branch_taken;
    assign w_redirect = w_branch | jump_req;
    assign w_imm_ext  = {{(PC_WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate};
    assign w_target   = w_branch ? (branch_pc + w_imm_ext) : jump_target;
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_run;
            r_cnt      <= '0;
            r_pc       <= c_reset_pc;
            r_pc_valid <= 1'b1;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                c_st_run: begin
                    if (halt) begin
                        r_state    <= c_st_halt;
                        r_pc_valid <= 1'b0;
                        r_halted   <= 1'b1;
                        if (w_redirect) begin
                            r_pc       <= w_target;
                            r_redirect <= 1'b1;
                        end
                    end else if (w_redirect) begin
                        r_state    <= c_st_flush;
                        r_pc       <= w_target;
                        r_redirect <= 1'b1;
                        r_flush    <= 1'b1;
                        r_cnt      <= c_flush_init;
                    end else if (!stall) begin
                        r_pc <= w_pc_inc;
                    end
                end
                c_st_flush: begin
                    // Redirect requests here come from killed instructions.
                    if (halt) begin
                        r_state    <= c_st_halt;
                        r_pc_valid <= 1'b0;
                        r_halted   <= 1'b1;
                        r_flush    <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        if (r_cnt == '0) begin
                            r_flush <= 1'b0;
                            r_state <= c_st_run;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                        if (!stall) begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                c_st_halt: begin
                    if (resume && !halt) begin
                        r_state    <= c_st_run;
                        r_pc_valid <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_st_run;
                    r_cnt      <= '0;
                    r_pc_valid <= 1'b1;
                    r_flush    <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;
    assign redirect = r_redirect;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Vector table plus randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_WIDTH     = 10;
    localparam int IMM_WIDTH    = 7;
    localparam int FLUSH_CYCLES = 2;
    localparam int PC_MOD       = 1 << PC_WIDTH;

    logic                 clk;
    logic                 rst;
    logic                 stall;
    logic                 branch_req;
    logic                 branch_taken;
    logic [PC_WIDTH-1:0]  branch_pc;
    logic [IMM_WIDTH-1:0] immediate;
    logic                 jump_req;
    logic [PC_WIDTH-1:0]  jump_target;
    logic                 halt;
    logic                 resume;
    logic [PC_WIDTH-1:0]  pc;
    logic                 pc_valid;
    logic                 flush;
    logic                 redirect;
    logic                 halted;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_WIDTH    (PC_WIDTH),
        .IMM_WIDTH   (IMM_WIDTH),
        .RESET_PC    (0),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_req  (branch_req),
        .branch_taken(branch_taken),
        .branch_pc   (branch_pc),
        .immediate   (immediate),
        .jump_req    (jump_req),
        .jump_target (jump_target),
        .halt        (halt),
        .resume      (resume),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .redirect    (redirect),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic     rst;
        logic     stall;
        logic     br;
        logic     tk;
        int       bpc;
        int       imm;
        logic     jr;
        int       jt;
        logic     halt;
        logic     resume;
        int       e_pc;
        logic     e_valid;
        logic     e_flush;
        logic     e_redir;
        logic     e_halted;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: halt flag plus number of flush cycles still to show.
    int   m_pc;
    int   m_flush_left;
    logic m_halt;
    logic m_redir;

    task automatic add(input logic r, input logic s, input logic br, input logic tk,
                       input int bpc, input int imm, input logic jr, input int jt,
                       input logic h, input logic rs, input int epc, input logic ev,
                       input logic ef, input logic er, input logic eh);
        vec_t v;
        v.rst = r; v.stall = s; v.br = br; v.tk = tk; v.bpc = bpc; v.imm = imm;
        v.jr = jr; v.jt = jt; v.halt = h; v.resume = rs;
        v.e_pc = epc; v.e_valid = ev; v.e_flush = ef; v.e_redir = er; v.e_halted = eh;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst          = v.rst;
        stall        = v.stall;
        branch_req   = v.br;
        branch_taken = v.tk;
        branch_pc    = PC_WIDTH'(v.bpc);
        immediate    = IMM_WIDTH'(v.imm);
        jump_req     = v.jr;
        jump_target  = PC_WIDTH'(v.jt);
        halt         = v.halt;
        resume       = v.resume;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input vec_t v);
        int  simm;
        int  tgt;
        logic take_br;
        logic redir;
        simm    = (v.imm >= (1 << (IMM_WIDTH-1))) ? v.imm - (1 << IMM_WIDTH) : v.imm;
        take_br = v.br && v.tk;
        redir   = take_br || v.jr;
        tgt     = take_br ? ((v.bpc + simm + PC_MOD) % PC_MOD) : v.jt;
        m_redir = 1'b0;
        if (v.rst) begin
            m_pc = 0; m_halt = 1'b0; m_flush_left = 0;
        end else if (m_halt) begin
            if (v.resume && !v.halt) m_halt = 1'b0;
        end else if (m_flush_left > 0) begin
            if (v.halt) begin
                m_halt = 1'b1; m_flush_left = 0;
            end else begin
                m_flush_left--;
                if (!v.stall) m_pc = (m_pc + 1) % PC_MOD;
            end
        end else if (v.halt) begin
            m_halt = 1'b1;
            if (redir) begin m_pc = tgt; m_redir = 1'b1; end
        end else if (redir) begin
            m_pc = tgt; m_redir = 1'b1; m_flush_left = FLUSH_CYCLES;
        end else if (!v.stall) begin
            m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; stall = 1'b0; branch_req = 1'b0; branch_taken = 1'b0;
        branch_pc = '0; immediate = '0; jump_req = 1'b0; jump_target = '0;
        halt = 1'b0; resume = 1'b0;

        //   rst s  br tk bpc  imm   jr jt   h  rs  pc  v  f  r  h
        add(1, 0, 0, 0, 0,    0,    0, 0,   0, 0,  0,  1, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, 1, 0, 0, 0);
        add(0, 0, 1, 1, 5,    'h7C, 0, 0,   0, 0,  1,  1, 1, 1, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  2,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  3,  1, 0, 0, 0);
        add(0, 0, 1, 1, 1020, 5,    0, 0,   0, 0,  1,  1, 1, 1, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  2,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  3,  1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    1, 1022,0, 0, 1022,1, 1, 1, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0, 1023,1, 1, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  0,  1, 0, 0, 0);
        add(0, 0, 1, 1, 30,   10,   1, 300, 0, 0,  40, 1, 1, 1, 0);
        add(0, 0, 1, 1, 100,  0,    0, 0,   0, 0,  41, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0,    0,    1, 200, 0, 0,  42, 1, 0, 0, 0);
        add(0, 0, 1, 0, 100,  0,    0, 0,   0, 0,  43, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    1, 9,   0, 0,  9,  1, 1, 1, 0);
        add(0, 1, 0, 0, 0,    0,    0, 0,   0, 0,  9,  1, 1, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  10, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0,    0,    1, 19,  0, 0,  19, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  20, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   1, 0,  20, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  20, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,    0,    0, 0,   1, 1,  20, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0,    0,    1, 77,  0, 0,  20, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 1,  20, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  21, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    1, 500, 1, 0, 500, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 1, 500, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0, 501, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    1, 600, 0, 0, 600, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0,    0,    0, 0,   0, 0,  0,  1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0,  1,  1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    1, 700, 0, 0, 700, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   1, 0, 700, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 1, 700, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   0, 0, 701, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,    0,    0, 0,   1, 0, 701, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0,    0,    0, 0,   0, 0,  0,  1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            chk($sformatf("vec%0d pc", i),       pc,       tbl[i].e_pc);
            chk($sformatf("vec%0d pc_valid", i), pc_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d flush", i),    flush,    tbl[i].e_flush);
            chk($sformatf("vec%0d redirect", i), redirect, tbl[i].e_redir);
            chk($sformatf("vec%0d halted", i),   halted,   tbl[i].e_halted);
        end

        // Randomized run; the first vector is a reset so the model starts aligned.
        for (int n = 0; n < 3000; n++) begin
            v.rst    = (n == 0) || ($urandom_range(0, 199) == 0);
            v.stall  = ($urandom_range(0, 4) == 0);
            v.br     = ($urandom_range(0, 5) == 0);
            v.tk     = $urandom_range(0, 1);
            v.bpc    = $urandom_range(0, PC_MOD - 1);
            v.imm    = $urandom_range(0, (1 << IMM_WIDTH) - 1);
            v.jr     = ($urandom_range(0, 9) == 0);
            v.jt     = $urandom_range(0, PC_MOD - 1);
            v.halt   = ($urandom_range(0, 24) == 0);
            v.resume = ($urandom_range(0, 3) == 0);
            drive(v);
            model_step(v);
            chk("rand pc",       pc,       m_pc);
            chk("rand pc_valid", pc_valid, !m_halt);
            chk("rand flush",    flush,    m_flush_left > 0);
            chk("rand redirect", redirect, m_redir);
            chk("rand halted",   halted,   m_halt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 10-bit program counter of the Mips16 core and decides the next fetch address each cycle. The choices are sequential increment, taken-branch target (branch PC plus sign-extended 7-bit immediate), jump target, stall-hold and halt. On every redirect it issues a fixed-length flush to the fetch/decode stages. It sits between the branch-resolution logic in decode/execute and the instruction memory address port.

Parameters:
PC_WIDTH, 10, width of PC and all address ports
IMM_WIDTH, 7, width of signed branch immediate
RESET_PC, 0, PC value loaded on reset
FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (1..7)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC this cycle
branch_req  input  1  a branch instruction is resolving this cycle
branch_taken  input  1  branch condition true (qualified by branch_req)
branch_pc  input  PC_WIDTH  PC of the resolving branch
immediate  input  IMM_WIDTH  two's-complement branch offset
jump_req  input  1  unconditional jump resolving this cycle
jump_target  input  PC_WIDTH  absolute jump address
halt  input  1  request halt
resume  input  1  leave HALT
pc  output  PC_WIDTH  current fetch address, registered
pc_valid  output  1  fetch address valid
flush  output  1  kill younger in-flight instructions
redirect  output  1  one-cycle pulse: pc was loaded from a branch or jump this cycle
halted  output  1  FSM in HALT

Behaviour:
- Reset: clk and rst, with rst sampled high: pc=RESET_PC, state=RUN, pc_valid=1, flush=0, redirect=0, halted=0, flush counter=0. Reset overrides everything, including mid-flush and HALT.
- Branch target: branch_pc + sign_extend(immediate) modulo 2^PC_WIDTH, with no PC+1 bias. Overflow and underflow wrap silently (1020+5 -> 1; 2+(-4) -> 1022).
- Sequential increment: pc+1 modulo 2^PC_WIDTH (1023 -> 0).
- Taken redirect = branch_req&branch_taken (branch) or jump_req. If both are asserted, the branch wins (it is the older instruction). branch_req with branch_taken=0 is not a redirect.
- States: RUN, FLUSH, HALT.
- RUN, per-edge priority:
  - halt+redirect: pc<=target, redirect=1, go to HALT.
  - halt: pc holds, go to HALT.
  - redirect: pc<=target, redirect=1, flush<=1, counter<=FLUSH_CYCLES-1, go to FLUSH.
  - stall: pc holds.
  - otherwise: pc<=pc+1.
- FLUSH:
  - flush=1. Counter decrements every cycle, stalled or not.
  - When the counter is 0 at the edge: flush<=0, go to RUN.
  - flush is therefore high for exactly FLUSH_CYCLES cycles, starting the cycle pc shows the target.
  - branch_req and jump_req are ignored, because they come from flushed instructions.
  - stall holds pc; otherwise pc increments.
  - halt: go to HALT, flush<=0, counter cleared.
- HALT:
  - pc holds, pc_valid=0, halted=1. stall and redirect inputs are ignored.
  - resume: go to RUN next edge; pc_valid=1 and halted=0 from that cycle. pc increments from the held value only on the following edge.
  - halt and resume together: stay in HALT.
- redirect is a registered pulse, high for the single cycle in which pc shows the new target.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then 5 free-run cycles -> pc=0,1,2,3,4,5; pc_valid=1; flush=0.
- Start at pc=6, branch_req=1, branch_taken=1, branch_pc=5, immediate=7'h7C (-4) -> next pc=1, redirect=1 for one cycle, flush high 2 cycles, pc then 2, 3.
- Branch wrap: branch_pc=1020, immediate=5 -> pc=1. Free-run across 1023 -> 0.
- Branch and jump together (jump_target=300, branch target=40) -> pc=40. A new branch_req during the flush window -> ignored, pc keeps incrementing.
- stall held 3 cycles at pc=10 -> pc stays 10. A redirect during stall in RUN -> the target is still loaded.
- halt at pc=20 -> pc=20, pc_valid=0, halted=1 while held. resume -> pc_valid=1 at 20, then 21. rst asserted mid-FLUSH -> pc=0, flush=0 next cycle.
